// File: rtl/dispatch_issue.sv
// Dispatch/issue stage: picks 0-2 in-order instructions from the queue
// heads, tracks pending load destinations and registers the issued pair.
module dispatch_issue #(
  parameter logic [2:0] LOAD_SEL   = 3'b101,
  parameter logic [2:0] MEM_SEL_LO = 3'b100,
  parameter logic [2:0] SERIAL_SEL = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             ex_stall,
  input  logic [1:0]       dispatch_inst_valid,
  input  logic [1:0][31:0] dispatch_pc_out,
  input  logic [1:0][31:0] dispatch_inst_out,
  input  logic [1:0][7:0]  dispatch_aluop,
  input  logic [1:0][2:0]  dispatch_alusel,
  input  logic [1:0][31:0] dispatch_imm,
  input  logic [1:0]       dispatch_reg_writen_en,
  input  logic [1:0]       dispatch_reg1_read_en,
  input  logic [1:0]       dispatch_reg2_read_en,
  input  logic [1:0][4:0]  dispatch_reg1_read_addr,
  input  logic [1:0][4:0]  dispatch_reg2_read_addr,
  input  logic [1:0][4:0]  dispatch_reg_write_addr,
  input  logic             wb_valid,
  input  logic [4:0]       wb_addr,
  output logic [1:0]       invalid_en,
  output logic [1:0]       issue_valid,
  output logic [1:0][31:0] issue_pc,
  output logic [1:0][31:0] issue_inst,
  output logic [1:0][7:0]  issue_aluop,
  output logic [1:0][2:0]  issue_alusel,
  output logic [1:0][31:0] issue_imm,
  output logic [1:0]       issue_reg_writen_en,
  output logic [1:0]       issue_reg1_read_en,
  output logic [1:0]       issue_reg2_read_en,
  output logic [1:0][4:0]  issue_reg1_read_addr,
  output logic [1:0][4:0]  issue_reg2_read_addr,
  output logic [1:0][4:0]  issue_reg_write_addr,
  output logic [31:0]      dual_issue_cnt,
  output logic [31:0]      hazard_stall_cnt
);

  logic [31:0] sb_q, sb_d, sb_eff, wb_clr, sb_set;
  logic [1:0]  hz, mem, ser;
  logic        dep, go0, go1, stall_evt;

  always_comb begin
    wb_clr = '0;
    if (wb_valid) wb_clr = 32'd1 << wb_addr;
    // a writeback this cycle releases its register immediately
    sb_eff = sb_q & ~wb_clr;
    hz  = '0;
    mem = '0;
    ser = '0;
    for (int i = 0; i < 2; i++) begin
      hz[i] = (dispatch_reg1_read_en[i] &&
               dispatch_reg1_read_addr[i] != 5'd0 &&
               sb_eff[dispatch_reg1_read_addr[i]]) ||
              (dispatch_reg2_read_en[i] &&
               dispatch_reg2_read_addr[i] != 5'd0 &&
               sb_eff[dispatch_reg2_read_addr[i]]) ||
              (dispatch_reg_writen_en[i] &&
               dispatch_reg_write_addr[i] != 5'd0 &&
               sb_eff[dispatch_reg_write_addr[i]]);
      mem[i] = dispatch_alusel[i] >= MEM_SEL_LO;
      ser[i] = dispatch_alusel[i] == SERIAL_SEL;
    end
    dep = dispatch_reg_writen_en[0] &&
          dispatch_reg_write_addr[0] != 5'd0 &&
          ((dispatch_reg1_read_en[1] &&
            dispatch_reg1_read_addr[1] == dispatch_reg_write_addr[0]) ||
           (dispatch_reg2_read_en[1] &&
            dispatch_reg2_read_addr[1] == dispatch_reg_write_addr[0]) ||
           (dispatch_reg_writen_en[1] &&
            dispatch_reg_write_addr[1] == dispatch_reg_write_addr[0]));
    go0 = dispatch_inst_valid[0] & ~hz[0] & ~ex_stall & ~flush;
    go1 = go0 & dispatch_inst_valid[1] & ~hz[1] & ~dep &
          ~ser[0] & ~ser[1] & ~(mem[0] & mem[1]);
    stall_evt = dispatch_inst_valid[0] & hz[0] & ~flush & ~ex_stall;
    sb_set = '0;
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 ? go0 : go1) &&
          dispatch_alusel[i] == LOAD_SEL &&
          dispatch_reg_writen_en[i] &&
          dispatch_reg_write_addr[i] != 5'd0)
        sb_set = sb_set | (32'd1 << dispatch_reg_write_addr[i]);
    end
    sb_d = ((sb_q & ~wb_clr) | sb_set) & ~32'd1;
    if (flush) sb_d = '0;
  end

  assign invalid_en = rst ? 2'b00 : {go1, go0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q                 <= '0;
      dual_issue_cnt       <= '0;
      hazard_stall_cnt     <= '0;
      issue_valid          <= '0;
      issue_pc             <= '0;
      issue_inst           <= '0;
      issue_aluop          <= '0;
      issue_alusel         <= '0;
      issue_imm            <= '0;
      issue_reg_writen_en  <= '0;
      issue_reg1_read_en   <= '0;
      issue_reg2_read_en   <= '0;
      issue_reg1_read_addr <= '0;
      issue_reg2_read_addr <= '0;
      issue_reg_write_addr <= '0;
    end else begin
      sb_q <= sb_d;
      if (go1) dual_issue_cnt <= dual_issue_cnt + 32'd1;
      if (stall_evt) hazard_stall_cnt <= hazard_stall_cnt + 32'd1;
      if (flush) begin
        issue_valid <= '0;
      end else if (!ex_stall) begin
        issue_valid          <= {go1, go0};
        issue_pc             <= dispatch_pc_out;
        issue_inst           <= dispatch_inst_out;
        issue_aluop          <= dispatch_aluop;
        issue_alusel         <= dispatch_alusel;
        issue_imm            <= dispatch_imm;
        issue_reg_writen_en  <= dispatch_reg_writen_en;
        issue_reg1_read_en   <= dispatch_reg1_read_en;
        issue_reg2_read_en   <= dispatch_reg2_read_en;
        issue_reg1_read_addr <= dispatch_reg1_read_addr;
        issue_reg2_read_addr <= dispatch_reg2_read_addr;
        issue_reg_write_addr <= dispatch_reg_write_addr;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_issue.sv
// Bench for dispatch_issue: directed scenarios plus random traffic,
// checked by a queue-fed monitor against a pending-load register model.
module tb_dispatch_issue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] imm;
    logic        we;
    logic        re1;
    logic        re2;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  wa;
  } ins_t;

  typedef struct {
    logic [1:0]  v;
    ins_t        i0;
    ins_t        i1;
    logic [31:0] dual;
    logic [31:0] haz;
  } snap_t;

  logic clk = 0;
  logic rst = 1;
  logic flush = 0, ex_stall = 0, wb_valid = 0;
  logic [4:0] wb_addr = 0;
  logic [1:0] d_v = 0;
  logic [1:0][31:0] d_pc = 0, d_inst = 0, d_imm = 0;
  logic [1:0][7:0] d_aluop = 0;
  logic [1:0][2:0] d_sel = 0;
  logic [1:0] d_we = 0, d_re1 = 0, d_re2 = 0;
  logic [1:0][4:0] d_a1 = 0, d_a2 = 0, d_wa = 0;

  logic [1:0] invalid_en, issue_valid;
  logic [1:0][31:0] issue_pc, issue_inst, issue_imm;
  logic [1:0][7:0] issue_aluop;
  logic [1:0][2:0] issue_alusel;
  logic [1:0] issue_we, issue_re1, issue_re2;
  logic [1:0][4:0] issue_a1, issue_a2, issue_wa;
  logic [31:0] dual_issue_cnt, hazard_stall_cnt;

  dispatch_issue dut (
    .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall),
    .dispatch_inst_valid(d_v),
    .dispatch_pc_out(d_pc),
    .dispatch_inst_out(d_inst),
    .dispatch_aluop(d_aluop),
    .dispatch_alusel(d_sel),
    .dispatch_imm(d_imm),
    .dispatch_reg_writen_en(d_we),
    .dispatch_reg1_read_en(d_re1),
    .dispatch_reg2_read_en(d_re2),
    .dispatch_reg1_read_addr(d_a1),
    .dispatch_reg2_read_addr(d_a2),
    .dispatch_reg_write_addr(d_wa),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .invalid_en(invalid_en),
    .issue_valid(issue_valid),
    .issue_pc(issue_pc),
    .issue_inst(issue_inst),
    .issue_aluop(issue_aluop),
    .issue_alusel(issue_alusel),
    .issue_imm(issue_imm),
    .issue_reg_writen_en(issue_we),
    .issue_reg1_read_en(issue_re1),
    .issue_reg2_read_en(issue_re2),
    .issue_reg1_read_addr(issue_a1),
    .issue_reg2_read_addr(issue_a2),
    .issue_reg_write_addr(issue_wa),
    .dual_issue_cnt(dual_issue_cnt),
    .hazard_stall_cnt(hazard_stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input bit ok, input string name,
                     input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // stimulus staged for the next cycle
  ins_t s_ins[2];
  logic [1:0] s_v = 0;
  logic s_flush = 0, s_stall = 0, s_wbv = 0;
  logic [4:0] s_wba = 0;

  // reference model state
  bit pend[32];
  ins_t e_ins[2];
  logic [1:0] e_v = 0;
  logic [31:0] e_dual = 0, e_haz = 0;

  logic [1:0] q_inv[$];
  snap_t q_iss[$];

  function automatic bit busy(input logic [4:0] r);
    return r != 0 && pend[r] && !(s_wbv && s_wba == r);
  endfunction

  function automatic bit hazard(input ins_t x);
    return (x.re1 && busy(x.a1)) || (x.re2 && busy(x.a2)) ||
           (x.we && busy(x.wa));
  endfunction

  function automatic bit depends(input ins_t p, input ins_t c);
    if (!p.we || p.wa == 0) return 0;
    return (c.re1 && c.a1 == p.wa) || (c.re2 && c.a2 == p.wa) ||
           (c.we && c.wa == p.wa);
  endfunction

  function automatic void model_reset();
    foreach (pend[r]) pend[r] = 0;
    e_v = 0;
    e_ins[0] = '0;
    e_ins[1] = '0;
    e_dual = 0;
    e_haz = 0;
  endfunction

  task automatic cyc();
    bit g0, g1, h0;
    snap_t s;
    @(negedge clk);
    flush = s_flush;
    ex_stall = s_stall;
    wb_valid = s_wbv;
    wb_addr = s_wba;
    d_v = s_v;
    for (int i = 0; i < 2; i++) begin
      d_pc[i] = s_ins[i].pc;
      d_inst[i] = s_ins[i].inst;
      d_aluop[i] = s_ins[i].aluop;
      d_sel[i] = s_ins[i].alusel;
      d_imm[i] = s_ins[i].imm;
      d_we[i] = s_ins[i].we;
      d_re1[i] = s_ins[i].re1;
      d_re2[i] = s_ins[i].re2;
      d_a1[i] = s_ins[i].a1;
      d_a2[i] = s_ins[i].a2;
      d_wa[i] = s_ins[i].wa;
    end
    h0 = hazard(s_ins[0]);
    g0 = s_v[0] && !h0 && !s_stall && !s_flush;
    g1 = g0 && s_v[1] && !hazard(s_ins[1]) &&
         !depends(s_ins[0], s_ins[1]) &&
         s_ins[0].alusel != 3'b111 && s_ins[1].alusel != 3'b111 &&
         !(s_ins[0].alusel >= 3'b100 && s_ins[1].alusel >= 3'b100);
    q_inv.push_back({g1, g0});
    if (g1) e_dual++;
    if (s_v[0] && h0 && !s_flush && !s_stall) e_haz++;
    if (s_flush) begin
      e_v = 0;
      foreach (pend[r]) pend[r] = 0;
    end else begin
      if (s_wbv) pend[s_wba] = 0;
      if (!s_stall) begin
        e_v = {g1, g0};
        e_ins[0] = s_ins[0];
        e_ins[1] = s_ins[1];
        for (int i = 0; i < 2; i++)
          if (e_v[i] && s_ins[i].alusel == 3'b101 &&
              s_ins[i].we && s_ins[i].wa != 0)
            pend[s_ins[i].wa] = 1;
      end
    end
    s.v = e_v;
    s.i0 = e_ins[0];
    s.i1 = e_ins[1];
    s.dual = e_dual;
    s.haz = e_haz;
    q_iss.push_back(s);
  endtask

  function automatic ins_t out_slot(input int i);
    ins_t x;
    x.pc = issue_pc[i];
    x.inst = issue_inst[i];
    x.aluop = issue_aluop[i];
    x.alusel = issue_alusel[i];
    x.imm = issue_imm[i];
    x.we = issue_we[i];
    x.re1 = issue_re1[i];
    x.re2 = issue_re2[i];
    x.a1 = issue_a1[i];
    x.a2 = issue_a2[i];
    x.wa = issue_wa[i];
    return x;
  endfunction

  // monitor: consume mask mid-cycle, issue register after the edge
  initial begin
    logic [1:0] ei;
    snap_t s;
    forever begin
      @(negedge clk);
      #2;
      if (q_inv.size() != 0) begin
        ei = q_inv.pop_front();
        chk(invalid_en === ei, "invalid_en", invalid_en, ei);
      end
      @(posedge clk);
      #1;
      if (q_iss.size() != 0) begin
        s = q_iss.pop_front();
        chk(issue_valid === s.v, "issue_valid", issue_valid, s.v);
        if (s.v[0])
          chk(out_slot(0) === s.i0, "issue_slot0", out_slot(0), s.i0);
        if (s.v[1])
          chk(out_slot(1) === s.i1, "issue_slot1", out_slot(1), s.i1);
        chk(dual_issue_cnt === s.dual, "dual_cnt", dual_issue_cnt, s.dual);
        chk(hazard_stall_cnt === s.haz, "haz_cnt", hazard_stall_cnt, s.haz);
      end
    end
  end

  function automatic ins_t mk(input logic [2:0] sel, input bit we,
                              input logic [4:0] wa, input bit re1,
                              input logic [4:0] a1, input bit re2,
                              input logic [4:0] a2);
    ins_t x;
    x.pc = $urandom;
    x.inst = $urandom;
    x.aluop = 8'($urandom);
    x.imm = $urandom;
    x.alusel = sel;
    x.we = we;
    x.wa = wa;
    x.re1 = re1;
    x.a1 = a1;
    x.re2 = re2;
    x.a2 = a2;
    return x;
  endfunction

  function automatic ins_t rnd();
    return mk(3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
              1'($urandom), 5'($urandom_range(0, 7)));
  endfunction

  task automatic idle_ctl();
    s_flush = 0;
    s_stall = 0;
    s_wbv = 0;
    s_wba = 0;
  endtask

  task automatic rnd_cycles(input int n);
    logic [4:0] r;
    for (int k = 0; k < n; k++) begin
      s_ins[0] = rnd();
      s_ins[1] = rnd();
      s_v = 2'($urandom);
      s_flush = $urandom_range(0, 19) == 0;
      s_stall = $urandom_range(0, 6) == 0;
      r = 5'($urandom_range(1, 7));
      s_wbv = pend[r] && $urandom_range(0, 2) == 0;
      s_wba = r;
      cyc();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    chk(invalid_en === 2'b00, "rst_invalid_en", invalid_en, 0);
    chk(issue_valid === 2'b00, "rst_issue_valid", issue_valid, 0);
    chk(dual_issue_cnt === 0, "rst_dual", dual_issue_cnt, 0);
    chk(hazard_stall_cnt === 0, "rst_haz", hazard_stall_cnt, 0);
    chk(issue_pc === '0, "rst_issue_pc", issue_pc, 0);
    model_reset();
    @(negedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    idle_ctl();
    s_ins[0] = '0;
    s_ins[1] = '0;
    d_v = 2'b11;
    #1;
    chk(invalid_en === 2'b00, "rst_mask_held", invalid_en, 0);
    d_v = 0;
    do_reset();

    // independent pair
    s_ins[0] = mk(3'd0, 1, 5'd4, 1, 5'd1, 1, 5'd2);
    s_ins[1] = mk(3'd1, 1, 5'd5, 1, 5'd6, 1, 5'd7);
    s_v = 2'b11;
    cyc();
    #2;
    chk(invalid_en === 2'b11, "pair_mask", invalid_en, 2'b11);
    // intra-pair RAW, then the reader as head
    s_ins[0] = mk(3'd0, 1, 5'd3, 0, 5'd0, 0, 5'd0);
    s_ins[1] = mk(3'd0, 1, 5'd2, 1, 5'd3, 0, 5'd0);
    cyc();
    s_ins[0] = s_ins[1];
    s_v = 2'b01;
    cyc();
    // load-use with writeback release
    s_ins[0] = mk(3'b101, 1, 5'd8, 1, 5'd1, 0, 5'd0);
    cyc();
    s_ins[0] = mk(3'd0, 1, 5'd2, 1, 5'd8, 0, 5'd0);
    cyc();
    cyc();
    #2;
    chk(invalid_en === 2'b00, "load_use_block", invalid_en, 0);
    s_wbv = 1;
    s_wba = 8;
    cyc();
    idle_ctl();
    // ex_stall hold for 3 cycles then resume
    s_ins[0] = mk(3'd0, 1, 5'd6, 0, 5'd0, 0, 5'd0);
    s_ins[1] = mk(3'd0, 1, 5'd7, 0, 5'd0, 0, 5'd0);
    s_v = 2'b11;
    s_stall = 1;
    repeat (3) cyc();
    s_stall = 0;
    cyc();
    // two loads pending, dual issue, then flush
    s_ins[0] = mk(3'b101, 1, 5'd8, 0, 5'd0, 0, 5'd0);
    s_ins[1] = mk(3'd0, 1, 5'd1, 0, 5'd0, 0, 5'd0);
    cyc();
    s_ins[0] = mk(3'd0, 1, 5'd2, 0, 5'd0, 0, 5'd0);
    s_ins[1] = mk(3'b101, 1, 5'd9, 0, 5'd0, 0, 5'd0);
    cyc();
    s_flush = 1;
    cyc();
    s_flush = 0;
    s_ins[0] = mk(3'd0, 1, 5'd9, 1, 5'd8, 0, 5'd0);
    s_v = 2'b01;
    cyc();
    // same-cycle load set and writeback of r10
    s_ins[0] = mk(3'b101, 1, 5'd10, 0, 5'd0, 0, 5'd0);
    s_wbv = 1;
    s_wba = 10;
    cyc();
    idle_ctl();
    s_ins[0] = mk(3'd0, 1, 5'd3, 1, 5'd10, 0, 5'd0);
    cyc();
    #2;
    chk(invalid_en === 2'b00, "r10_still_busy", invalid_en, 0);
    s_wbv = 1;
    s_wba = 10;
    cyc();
    idle_ctl();
    // two memory ops; serial op in slot 0
    s_ins[0] = mk(3'b100, 0, 5'd0, 1, 5'd1, 0, 5'd0);
    s_ins[1] = mk(3'b110, 0, 5'd0, 1, 5'd2, 0, 5'd0);
    s_v = 2'b11;
    cyc();
    #2;
    chk(invalid_en === 2'b01, "two_mem", invalid_en, 2'b01);
    s_ins[0] = mk(3'b111, 0, 5'd0, 0, 5'd0, 0, 5'd0);
    s_ins[1] = mk(3'd0, 1, 5'd4, 0, 5'd0, 0, 5'd0);
    cyc();
    // slot1 alone is never issued
    s_v = 2'b10;
    cyc();

    rnd_cycles(500);
    do_reset();
    rnd_cycles(300);
    idle_ctl();
    s_v = 0;
    cyc();
    @(posedge clk);
    #3;
    chk(q_iss.size() == 0 && q_inv.size() == 0, "queues_drained",
        q_iss.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dispatch_issue.md
Name: dispatch_issue

Overview:
- Consumer end of the decoded-instruction queue. Each cycle it examines the two queue heads, checks register hazards against a load scoreboard and between the pair, and issues 0, 1 or 2 instructions in order.
- Issued instructions are registered toward the two execute pipes.
- It returns the per-slot consume mask `invalid_en` to the queue, which dequeues those entries at the same clock edge.

Parameters:
- LOAD_SEL, 3'b101, alusel value marking a load; its destination is tracked in the scoreboard.
- MEM_SEL_LO, 3'b100, alusel values >= this are memory ops; at most one memory op issues per cycle.
- SERIAL_SEL, 3'b111, alusel value for branch/CSR/privileged ops; these always issue alone, in slot 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush from backend
- ex_stall  in  1  execute stage cannot accept; hold outputs
- dispatch_inst_valid  in  2  queue head valid per slot
- dispatch_pc_out, dispatch_inst_out  in  2x32 each  PC / instruction per slot
- dispatch_aluop  in  2x8;  dispatch_alusel  in  2x3;  dispatch_imm  in  2x32
- dispatch_reg_writen_en, dispatch_reg1_read_en, dispatch_reg2_read_en  in  2 each
- dispatch_reg1_read_addr, dispatch_reg2_read_addr, dispatch_reg_write_addr  in  2x5 each
- wb_valid  in  1  load writeback occurred
- wb_addr  in  5  load writeback destination
- invalid_en  out  2  combinational consume mask to the queue
- issue_valid  out  2  registered issue valid per pipe
- issue_pc, issue_inst, issue_aluop, issue_alusel, issue_imm, issue_reg_writen_en, issue_reg1_read_en, issue_reg2_read_en, issue_reg1_read_addr, issue_reg2_read_addr, issue_reg_write_addr  out  same widths as the matching dispatch_* inputs  registered copies
- dual_issue_cnt  out  32  cycles in which 2 instructions issued
- hazard_stall_cnt  out  32  cycles in which slot 0 was valid but blocked by the scoreboard

Behaviour:
- Reset: all outputs 0, scoreboard 0, counters 0.
- hazard(i): slot i has a read port with read_en=1, addr!=0 and the scoreboard bit set; or reg_writen_en=1, dest!=0 and the dest scoreboard bit set (WAW).
- go0 = valid[0] & !hazard(0) & !ex_stall & !flush.
- go1 = go0 & valid[1] & !hazard(1), and additionally:
  - slot 0 dest (writen_en=1, !=0) does not match any enabled read addr or the write addr of slot 1;
  - neither slot has alusel==SERIAL_SEL;
  - not (both alusel >= MEM_SEL_LO).
- valid[1] with valid[0]=0 is never issued.
- invalid_en = {go1, go0}; combinational, 0 during flush or ex_stall.
- Issue register, updated on clk:
  - flush: issue_valid <= 0.
  - else ex_stall: hold all issue_* values.
  - else: issue_valid <= {go1, go0} and fields load from the matching slot. Fields of a non-issued slot are don't-care; issue_valid=0 for that slot.
- Latency: queue head to issue_* is 1 cycle.
- Scoreboard (32 bits; bit 0 is never set):
  - Set on issue of a slot with alusel==LOAD_SEL, writen_en=1, dest!=0.
  - Clear on wb_valid at wb_addr.
  - Set and clear of the same register in the same cycle: set wins.
  - Flush clears every bit. The backend guarantees no wb_valid for loads squashed by the flush.
- Counters:
  - dual_issue_cnt increments when go1=1.
  - hazard_stall_cnt increments when valid[0] & hazard(0) & !flush & !ex_stall.
  - Both wrap at 2^32. Flush does not clear them.
- rst asserted mid-operation zeroes all state asynchronously. invalid_en is 0 while rst is high.

Test Plan:
1. Independent pair: `add` r4 (slot0), `sub` r5 reading r6/r7 (slot1), both valid -> invalid_en=2'b11; next cycle issue_valid=2'b11, issue_reg_write_addr={5,4}; dual_issue_cnt=1.
2. Intra-pair RAW: slot0 writes r3, slot1 reads r3 -> invalid_en=2'b01. Next cycle the r3 reader is the slot0 head and issues alone.
3. Load-use: issue `ld` to r8; then a head reading r8 -> invalid_en=0 and hazard_stall_cnt increments each cycle. Assert wb_valid, wb_addr=8 -> the reader issues on that cycle's edge; bit 8 is cleared.
4. ex_stall high for 3 cycles with valid heads -> invalid_en=0 and issue_* held unchanged. Deassert -> issue resumes in the same cycle.
5. Flush while scoreboard has bits 8 and 9 set and issue_valid=2'b11 -> next cycle issue_valid=0 and scoreboard=0; invalid_en=0 during the flush cycle.
6. Same-cycle load issue to r10 and wb_valid with wb_addr=10 -> bit 10 remains set. Two memory ops or a SERIAL_SEL op in slot0 -> invalid_en=2'b01.
